// File: rtl/pci_target.sv
// pci_target: PCI-style burst target that claims an address window and
// serves burst reads/writes from a local word memory, with optional wait states.
module pci_target #(
    parameter int BASE_ADDR   = 20,
    parameter int DEPTH       = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire logic        iframe,
    inout  wire logic [31:0] AD,
    inout  wire logic [3:0]  CBE,
    inout  wire logic        iready,
    inout  wire logic        tready,
    inout  wire logic        devsel,
    output logic             hit,
    output logic             busy
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LO = 32'(BASE_ADDR);
    localparam logic [31:0] HI = 32'(BASE_ADDR + DEPTH);
    typedef enum logic [2:0] {IDLE, IGNORE, WR, RD_TA, RD_DATA, TA} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_nx;
    logic [2:0]    wcnt_q;
    logic          rdy_q, hit_q;
    logic [31:0]   mem_q [DEPTH];
    logic          cmd_wr, cmd_rd, claim, xfer;
    logic          dv_oe, dv_v, tr_v, ad_oe;
    assign cmd_wr = CBE == 4'b1000;
    assign cmd_rd = CBE == 4'b0000;
    assign claim  = state_q == IDLE && !iframe && AD >= LO && AD < HI && (cmd_wr || cmd_rd);
    // a data phase completes only against the tready value this block is driving
    assign xfer   = (state_q == WR || state_q == RD_DATA) && rdy_q && !iready;
    assign idx_nx = idx_q == IW'(DEPTH - 1) ? '0 : idx_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = iframe ? IDLE : !claim ? IGNORE : cmd_wr ? WR : RD_TA;
            IGNORE:      state_d = iframe && iready ? IDLE : IGNORE;
            WR, RD_DATA: state_d = iframe ? TA : state_q;
            RD_TA:       state_d = RD_DATA;
            default:     state_d = IDLE;
        endcase
    end
    always_comb begin
        dv_oe = state_q inside {WR, RD_TA, RD_DATA, TA};
        dv_v  = state_q == TA;
        tr_v  = !(rdy_q && (state_q == WR || state_q == RD_DATA));
        ad_oe = state_q == RD_DATA;
        busy  = state_q != IDLE;
        hit   = hit_q;
    end
    assign devsel = dv_oe ? dv_v : 1'bz;
    assign tready = dv_oe ? tr_v : 1'bz;
    assign AD     = ad_oe ? mem_q[idx_q] : 'z;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            wcnt_q <= '0;
            rdy_q  <= 1'b0;
            hit_q  <= 1'b0;
            for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
        end else begin
            hit_q <= claim;
            if (claim) begin
                idx_q  <= IW'(AD - LO);
                wcnt_q <= 3'(WAIT_STATES);
                rdy_q  <= cmd_wr && WAIT_STATES == 0;
            end else if (state_q == RD_TA) begin
                rdy_q <= wcnt_q == 3'd0;
            end else if ((state_q == WR || state_q == RD_DATA) && !rdy_q) begin
                wcnt_q <= wcnt_q - 3'd1;
                rdy_q  <= wcnt_q == 3'd1;
            end
            if (xfer) idx_q <= idx_nx;
            if (xfer && state_q == WR)
                for (int i = 0; i < 4; i++)
                    if (!CBE[i]) mem_q[idx_q][8*i +: 8] <= AD[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_pci_target.sv
// tb_pci_target: two targets (base 20 no waits, base 40 two wait states) on one
// pulled-up bus; read data is checked against a scoreboard fed from a memory model.
module tb_pci_target;
    logic        clk = 0, rst = 1;
    logic        fr = 1, ir = 1, ad_oe = 0;
    logic [31:0] ad_drv = '0;
    logic [3:0]  cbe = 4'hf;
    wire         iframe, iready, tready, devsel;
    wire  [31:0] AD;
    wire  [3:0]  CBE;
    logic        hit0, hit1, busy0, busy1;
    int          n_chk = 0, n_err = 0;
    logic [31:0] mdl [2][10];
    logic [31:0] exp_q [$];
    logic [31:0] wd [8];
    logic [3:0]  wb [8];
    localparam logic [3:0] CW = 4'b1000, CR = 4'b0000;

    assign iframe = fr;
    assign iready = ir;
    assign CBE    = cbe;
    assign AD     = ad_oe ? ad_drv : 'z;
    pullup (devsel);
    pullup (tready);
    pullup pu_ad [31:0] (AD);
    always #5 clk = ~clk;

    pci_target #(.BASE_ADDR(20), .DEPTH(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .iframe(iframe), .AD(AD), .CBE(CBE), .iready(iready),
        .tready(tready), .devsel(devsel), .hit(hit0), .busy(busy0));
    pci_target #(.BASE_ADDR(40), .DEPTH(10), .WAIT_STATES(2)) u_dut1 (
        .clk(clk), .rst(rst), .iframe(iframe), .AD(AD), .CBE(CBE), .iready(iready),
        .tready(tready), .devsel(devsel), .hit(hit1), .busy(busy1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int d = 0; d < 2; d++)
            for (int j = 0; j < 10; j++) mdl[d][j] = '0;
    endtask

    task automatic end_txn;
        ad_oe = 0; ir = 1; cbe = 4'hf;
        #1;
        check("devsel_ta", devsel, 1);
        check("tready_ta", tready, 1);
        check("ad_ta_released", AD, 32'hFFFF_FFFF);
        check("busy_ta", busy0 | busy1, 1);
        check("hit_cleared", hit0 | hit1, 0);
        cyc;
        check("busy_idle", {busy0, busy1}, 0);
        check("devsel_released", devsel, 1);
    endtask

    task automatic txn(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                       input int iw, input int rst_k);
        int d, id, tw;
        bit wr, done;
        wr = cmd == CW;
        d  = addr >= 40 ? 1 : 0;
        id = int'(addr) - (d ? 40 : 20);
        if (!wr)
            for (int k = 0; k < n; k++) exp_q.push_back(mdl[d][(id + k) % 10]);
        cyc;
        fr = 0; ir = 1; ad_oe = 1; ad_drv = addr; cbe = cmd;
        cyc;
        if (!wr) ad_oe = 0;
        #1;
        check("hit_claim", d ? hit1 : hit0, 1);
        check("devsel_claim", devsel, 0);
        check("tready_claim", tready, (wr && d == 0) ? 0 : 1);
        if (!wr) begin
            check("ad_turnaround", AD, 32'hFFFF_FFFF);
            cyc;
        end
        for (int k = 0; k < n; k++) begin
            tw = 0;
            done = 0;
            for (int c = 0; c < 20 && !done; c++) begin
                if (c > 0) cyc;
                if (k == rst_k && c == 0) begin
                    check("devsel_pre_rst", devsel, 0);
                    rst = 1;
                    #1;
                    check("devsel_rst", devsel, 1);
                    check("tready_rst", tready, 1);
                    check("busy_rst", {busy0, busy1}, 0);
                    check("hit_rst", hit0 | hit1, 0);
                    fr = 1; ir = 1; ad_oe = 0; cbe = 4'hf;
                    clear_model();
                    cyc;
                    rst = 0;
                    return;
                end
                if (wr) begin
                    ad_drv = wd[k];
                    cbe = wb[k];
                end
                ir = c < iw ? 1 : 0;
                if (tready !== 1'b0) tw++;
                done = !ir && tready === 1'b0;
                fr = (done && k == n - 1) ? 1 : 0;
                if (done) begin
                    if (wr) begin
                        for (int i = 0; i < 4; i++)
                            if (!wb[k][i]) mdl[d][id][8*i +: 8] = wd[k][8*i +: 8];
                    end else begin
                        check("rd_data", AD, exp_q.pop_front());
                    end
                    id = (id + 1) % 10;
                end
            end
            if (!done) check("phase_timeout", 0, 1);
            if (k == 0 && iw == 0) check("tready_waits", tw, d ? 2 : 0);
            cyc;
        end
        end_txn();
    endtask

    task automatic miss(input logic [31:0] addr, input logic [3:0] cmd);
        cyc;
        fr = 0; ir = 1; ad_oe = 1; ad_drv = addr; cbe = cmd;
        cyc;
        ad_oe = 0;
        #1;
        check("miss_hit", {hit0, hit1}, 0);
        check("miss_devsel", devsel, 1);
        check("miss_tready", tready, 1);
        check("miss_ad", AD, 32'hFFFF_FFFF);
        check("miss_busy", {busy0, busy1}, 2'b11);
        cyc;
        check("miss_busy_hold", busy0, 1);
        fr = 1; ir = 1; cbe = 4'hf;
        cyc;
        check("miss_busy_clear", {busy0, busy1}, 0);
    endtask

    task automatic abort_read(input logic [31:0] addr);
        cyc;
        fr = 0; ir = 1; ad_oe = 1; ad_drv = addr; cbe = CR;
        cyc;
        ad_oe = 0;
        #1;
        check("abort_hit", hit1, 1);
        check("abort_devsel", devsel, 0);
        cyc;
        check("abort_tready_wait", tready, 1);
        fr = 1; ir = 1;
        cyc;
        check("abort_devsel_ta", devsel, 1);
        check("abort_busy_ta", busy1, 1);
        cyc;
        check("abort_busy_idle", busy1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_model();
        repeat (2) cyc;
        check("rst_devsel", devsel, 1);
        check("rst_tready", tready, 1);
        check("rst_ad", AD, 32'hFFFF_FFFF);
        check("rst_hit_busy", {hit0, hit1, busy0, busy1}, 0);
        rst = 0;
        wd[0] = 32'h7667_7667; wb[0] = 4'b0000;
        txn(20, CW, 1, 0, -1);
        txn(20, CR, 1, 0, -1);
        wd[0] = 32'hAAAA_0008; wd[1] = 32'hBBBB_0009; wd[2] = 32'hCCCC_0000;
        wb[0] = 4'b0000; wb[1] = 4'b0000; wb[2] = 4'b0000;
        txn(28, CW, 3, 0, -1);
        txn(28, CR, 3, 0, -1);
        wd[0] = 32'h1234_5678;
        txn(21, CW, 1, 0, -1);
        wd[0] = 32'hFFFF_0000; wb[0] = 4'b1100;
        txn(21, CW, 1, 2, -1);
        txn(21, CR, 1, 0, -1);
        miss(10, CW);
        miss(20, 4'b0110);
        wd[0] = 32'hDEAD_BEEF; wd[1] = 32'h0BAD_F00D; wb[0] = 4'b0000; wb[1] = 4'b0000;
        txn(40, CW, 2, 0, -1);
        txn(40, CR, 2, 0, -1);
        abort_read(45);
        txn(40, CR, 2, 1, -1);
        wd[0] = 32'h0000_0001; wd[1] = 32'h0000_0002; wd[2] = 32'h0000_0003;
        wb[0] = 4'b0000; wb[1] = 4'b0000; wb[2] = 4'b0000;
        txn(22, CW, 3, 0, 1);
        txn(20, CR, 3, 0, -1);
        txn(40, CR, 1, 0, -1);
        wd[0] = 32'h5A5A_5A5A; wb[0] = 4'b0000;
        txn(25, CW, 1, 0, -1);
        txn(25, CR, 1, 0, -1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pci_target.md
Name: pci_target

Overview:
- Dedicated PCI-style target (responder) for the shared bus driven by `device` initiators and granted by `ARBITER`.
- Decodes the address phase and claims hits with devsel/tready.
- Accepts burst writes into, or returns burst reads from, a local word memory.
- All bus control signals are active-low on the shared inout nets.

Parameters:
- BASE_ADDR, 20: first bus address claimed.
- DEPTH, 10: number of 32-bit memory words; claimed range is BASE_ADDR .. BASE_ADDR+DEPTH-1.
- WAIT_STATES, 0: cycles tready is held high after devsel before the first data phase (0..7).

Ports:
- clk  input  1  bus clock; all sampling and driving on posedge.
- rst  input  1  asynchronous, active-high reset.
- iframe  inout  1  initiator frame, active low; this block only samples it.
- AD  inout  32  multiplexed address/data.
- CBE  inout  4  command in address phase, byte enables (active low) in data phase; sampled only.
- iready  inout  1  initiator ready, active low; sampled only.
- tready  inout  1  target ready, active low; driven only while claimed, else z.
- devsel  inout  1  device select, active low; driven only while claimed, else z.
- hit  output  1  one-cycle pulse on the cycle a transaction is claimed.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async):
  - tready, devsel, AD released to z; hit=0, busy=0; state IDLE; idx=0; wait counter 0.
  - All memory words cleared to 0.
  - Reset mid-transfer aborts immediately: no partial memory write on that edge.
- Commands: CBE=4'b1000 is write, 4'b0000 is read. Any other value is not claimed.
- Address phase: in IDLE, a posedge sampling iframe=0.
  - Claim requires BASE_ADDR <= AD < BASE_ADDR+DEPTH and a valid command.
  - On a claim: idx = AD-BASE_ADDR, hit=1 for one cycle, devsel driven 0 from this edge.
  - Write claim: go to WR. Read claim: go to RD_TA.
  - No claim: go to IGNORE.
- IGNORE: wait until iframe=1 and iready=1 are both sampled, then return to IDLE. Nothing is driven.
- Wait states: the counter loads WAIT_STATES at claim. tready stays 1 until the counter reaches 0.
  - Write: tready driven 0 on the claim edge when WAIT_STATES=0.
  - Read: tready is never earlier than RD_DATA.
- RD_TA: one turnaround cycle in which AD is still z.
  - Next edge: drive AD=mem[idx], enable AD output, go to RD_DATA.
- Transfer rule: a data phase completes on a posedge sampling iready=0 and tready=0 (tready as driven by this block). No completion otherwise; both sides may insert waits indefinitely.
- WR, on completion: for each byte lane i with CBE[i]=0, write mem[idx][8i+7:8i] = AD[8i+7:8i]. Lanes with CBE[i]=1 are unchanged; CBE=4'b1111 is a valid no-op phase. Then idx advances.
- RD_DATA, on completion: idx advances and AD is updated to mem[new idx] on the same edge. Next data is valid one cycle later, with no extra wait.
- idx wraps DEPTH-1 -> 0 when the burst continues.
- Last phase: a completion with iframe sampled 1 ends the burst and enters TA.
  - TA lasts one cycle: devsel and tready are driven 1, AD is released to z.
  - Next edge: all released to z, state IDLE.
- iframe sampled 1 with no completion pending (initiator abort): enter TA directly, no memory update.
- A new iframe=0 sampled during TA is ignored. The next address phase is recognised only from IDLE.
- This block never drives iframe, iready or CBE.

Test Plan:
- Single write: AD=20, CBE=1000, then data 32'h7667_7667 with CBE=0000, iready=0, iframe high on the data phase. Expect: hit pulse, devsel/tready=0 the same cycle, mem[0]=32'h76677667, devsel/tready=1 for one cycle, then z.
- Burst read with wrap: preload mem[8]=A, mem[9]=B, mem[0]=C. Address 28, read, 3 data phases. Expect: AD z for one cycle, then A, B, C on consecutive completions; idx wraps to 0.
- Byte enables and waits: write 32'hFFFF_0000 with CBE=4'b1100 to address 21, where mem[1]=32'h1234_5678. Hold iready=1 for 2 cycles before asserting it. Expect: mem[1]=32'h1234_0000, written only on the edge where iready=0.
- Miss and bad command: address 10, then address 20 with CBE=0110. Expect: devsel/tready/AD stay z, hit=0, busy high until iframe/iready are both high.
- WAIT_STATES=2 read: tready deasserted for 2 cycles after RD_TA, then data. Initiator abort (iframe=1 before any completion) yields TA with no memory change.
- Reset mid-burst: assert rst during the 2nd write phase. Expect: all outputs z asynchronously, busy=0, memory all zero; the next transaction is claimed normally.
